// File: rtl/beta_dec_issue_stage.sv
// rtl/beta_dec_issue_stage.sv - decode-to-execute issue stage with register write scoreboard
//
// Purpose: holds one decoded instruction in an output pipeline register. A per-register
// scoreboard marks destinations whose writes have issued but not yet written back. The
// stage stalls on RAW/WAW hazards and bypasses same-cycle writeback data into operands.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop the held instruction and refuse input this cycle
//   in_*                  decoded instruction (valid/ready handshake)
//   wb_*                  writeback port (clears scoreboard bits, bypass source)
//   out_*                 issued instruction to execute (valid/ready handshake)
//   busy_o                held instruction or any outstanding write
//   stall_cnt_o           saturating count of hazard stall cycles
module beta_dec_issue_stage #(
    parameter int DataWidth     = 32,
    parameter int NumRegs       = 32,
    parameter int CwWidth       = 32,
    parameter int StallCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [4:0]               in_rs1_addr_i,
    input  logic [4:0]               in_rs2_addr_i,
    input  logic                     in_rs1_used_i,
    input  logic                     in_rs2_used_i,
    input  logic [4:0]               in_rd_addr_i,
    input  logic                     in_rd_wr_i,
    input  logic [DataWidth-1:0]     in_op_a_i,
    input  logic [DataWidth-1:0]     in_op_b_i,
    input  logic                     in_op_a_is_rs1_i,
    input  logic                     in_op_b_is_rs2_i,
    input  logic [DataWidth-1:0]     in_pc_i,
    input  logic [CwWidth-1:0]       in_cw_i,
    input  logic                     wb_valid_i,
    input  logic [4:0]               wb_rd_addr_i,
    input  logic [DataWidth-1:0]     wb_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DataWidth-1:0]     out_op_a_o,
    output logic [DataWidth-1:0]     out_op_b_o,
    output logic [4:0]               out_rd_addr_o,
    output logic                     out_rd_wr_o,
    output logic [DataWidth-1:0]     out_pc_o,
    output logic [CwWidth-1:0]       out_cw_o,
    output logic                     out_illegal_o,
    output logic                     busy_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    logic [NumRegs-1:0]       sb_q;
    logic [31:0]              sb_ext;
    logic [31:0]              sb_next;
    logic [StallCntWidth-1:0] stall_cnt_q;
    logic                     held_wr;
    logic                     illegal;
    logic                     rs1_res, rs2_res, rd_res;
    logic                     hazard;
    logic                     accept;
    logic                     issue;

    // Zero-extended to the full 5-bit address space so out-of-range addresses read as
    // never pending.
    assign sb_ext  = 32'(sb_q);
    assign held_wr = out_valid_o & out_rd_wr_o;

    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < NumRegs;
    endfunction

    function automatic logic pending(input logic [4:0] a, input logic [31:0] sb,
                                     input logic hw, input logic [4:0] hrd);
        return (a != 5'd0) && (sb[a] || (hw && hrd == a));
    endfunction

    // A writeback resolves a hazard only for a write that has already left this stage;
    // a write still held here is younger than anything on the writeback port.
    function automatic logic resolved(input logic [4:0] a, input logic [31:0] sb,
                                      input logic hw, input logic [4:0] hrd,
                                      input logic wv, input logic [4:0] wrd);
        return wv && (wrd == a) && (a != 5'd0) && sb[a] && !(hw && hrd == a);
    endfunction

    assign illegal = (in_rs1_used_i && !in_range(in_rs1_addr_i))
                   | (in_rs2_used_i && !in_range(in_rs2_addr_i))
                   | (in_rd_wr_i    && !in_range(in_rd_addr_i));

    assign rs1_res = resolved(in_rs1_addr_i, sb_ext, held_wr, out_rd_addr_o, wb_valid_i, wb_rd_addr_i);
    assign rs2_res = resolved(in_rs2_addr_i, sb_ext, held_wr, out_rd_addr_o, wb_valid_i, wb_rd_addr_i);
    assign rd_res  = resolved(in_rd_addr_i,  sb_ext, held_wr, out_rd_addr_o, wb_valid_i, wb_rd_addr_i);

    assign hazard = in_valid_i && (
          (in_rs1_used_i && pending(in_rs1_addr_i, sb_ext, held_wr, out_rd_addr_o) && !rs1_res)
        | (in_rs2_used_i && pending(in_rs2_addr_i, sb_ext, held_wr, out_rd_addr_o) && !rs2_res)
        | (in_rd_wr_i && (in_rd_addr_i != 5'd0)
                      && pending(in_rd_addr_i, sb_ext, held_wr, out_rd_addr_o) && !rd_res));

    assign in_ready_o  = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign issue       = out_valid_o && out_ready_i;
    assign busy_o      = out_valid_o || (|sb_q);
    assign stall_cnt_o = stall_cnt_q;

    // Set from an issuing write is applied after the writeback clear so it wins.
    always_comb begin
        sb_next = sb_ext;
        if (wb_valid_i) begin
            sb_next[wb_rd_addr_i] = 1'b0;
        end
        if (issue && out_rd_wr_o && (out_rd_addr_o != 5'd0)) begin
            sb_next[out_rd_addr_o] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q <= sb_next[NumRegs-1:0];
            if (hazard && !flush_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + StallCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o   <= 1'b0;
            out_op_a_o    <= '0;
            out_op_b_o    <= '0;
            out_rd_addr_o <= '0;
            out_rd_wr_o   <= 1'b0;
            out_pc_o      <= '0;
            out_cw_o      <= '0;
            out_illegal_o <= 1'b0;
        end else if (accept) begin
            out_valid_o   <= 1'b1;
            out_op_a_o    <= (in_op_a_is_rs1_i && rs1_res) ? wb_data_i : in_op_a_i;
            out_op_b_o    <= (in_op_b_is_rs2_i && rs2_res) ? wb_data_i : in_op_b_i;
            out_rd_addr_o <= in_rd_addr_i;
            out_rd_wr_o   <= in_rd_wr_i && !illegal;
            out_pc_o      <= in_pc_i;
            out_cw_o      <= in_cw_i;
            out_illegal_o <= illegal;
        end else if (issue || flush_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beta_dec_issue_stage.sv
// tb/tb_beta_dec_issue_stage.sv - scoreboard bench for beta_dec_issue_stage
module tb_beta_dec_issue_stage;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int CW = 32;
    localparam int SW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i, in_valid_i, in_ready_o;
    logic [4:0]    in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i;
    logic          in_rs1_used_i, in_rs2_used_i, in_rd_wr_i;
    logic [DW-1:0] in_op_a_i, in_op_b_i, in_pc_i;
    logic          in_op_a_is_rs1_i, in_op_b_is_rs2_i;
    logic [CW-1:0] in_cw_i;
    logic          wb_valid_i;
    logic [4:0]    wb_rd_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] out_op_a_o, out_op_b_o, out_pc_o;
    logic [4:0]    out_rd_addr_o;
    logic          out_rd_wr_o, out_illegal_o, busy_o;
    logic [CW-1:0] out_cw_o;
    logic [SW-1:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    beta_dec_issue_stage #(.DataWidth(DW), .NumRegs(NR), .CwWidth(CW), .StallCntWidth(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
        .in_rs1_used_i(in_rs1_used_i), .in_rs2_used_i(in_rs2_used_i),
        .in_rd_addr_i(in_rd_addr_i), .in_rd_wr_i(in_rd_wr_i),
        .in_op_a_i(in_op_a_i), .in_op_b_i(in_op_b_i),
        .in_op_a_is_rs1_i(in_op_a_is_rs1_i), .in_op_b_is_rs2_i(in_op_b_is_rs2_i),
        .in_pc_i(in_pc_i), .in_cw_i(in_cw_i),
        .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_a_o(out_op_a_o), .out_op_b_o(out_op_b_o),
        .out_rd_addr_o(out_rd_addr_o), .out_rd_wr_o(out_rd_wr_o),
        .out_pc_o(out_pc_o), .out_cw_o(out_cw_o), .out_illegal_o(out_illegal_o),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        logic          v, u1, u2, wr, a1, b2, flush, ordy, wbv;
        logic [4:0]    rs1, rs2, rd, wbrd;
        logic [DW-1:0] a, b, pc, wbd;
        logic [CW-1:0] cw;
    } stim_t;

    typedef struct {
        logic [DW-1:0] a, b, pc;
        logic [4:0]    rd;
        logic          wr, ill;
        logic [CW-1:0] cw;
    } exp_t;

    exp_t q[$];          // q[0] is the instruction the output register should hold
    bit   pend[32];      // writes that have left the stage but not written back
    int   stall_m;
    bit   in_reset = 1'b1;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit held_writes(input logic [4:0] r);
        return (q.size() != 0) && q[0].wr && (q[0].rd == r);
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        return (r != 5'd0) && (pend[r] || held_writes(r));
    endfunction

    function automatic bit m_resolved(input logic [4:0] r, input stim_t s);
        return s.wbv && (s.wbrd == r) && (r != 5'd0) && pend[r] && !held_writes(r);
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < 32; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.u1 = 0; s.u2 = 0; s.wr = 0; s.a1 = 0; s.b2 = 0;
        s.flush = 0; s.ordy = 1; s.wbv = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.wbrd = 0;
        s.a = 0; s.b = 0; s.pc = 0; s.wbd = 0; s.cw = 0;
        return s;
    endfunction

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 19) == 0) return 5'($urandom_range(16, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = idle();
        s.v = ($urandom_range(0, 3) != 0);
        s.rs1 = raddr(); s.rs2 = raddr(); s.rd = raddr();
        s.u1 = 1'($urandom_range(0, 1)); s.u2 = 1'($urandom_range(0, 1));
        s.wr = 1'($urandom_range(0, 1));
        s.a1 = 1'($urandom_range(0, 1)); s.b2 = 1'($urandom_range(0, 1));
        s.flush = ($urandom_range(0, 15) == 0);
        s.ordy = ($urandom_range(0, 3) != 0);
        s.wbv = ($urandom_range(0, 2) == 0);
        s.wbrd = 5'($urandom_range(0, 7));
        s.a = $urandom; s.b = $urandom; s.pc = $urandom; s.wbd = $urandom; s.cw = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        in_valid_i = s.v; flush_i = s.flush; out_ready_i = s.ordy;
        in_rs1_addr_i = s.rs1; in_rs2_addr_i = s.rs2; in_rd_addr_i = s.rd;
        in_rs1_used_i = s.u1; in_rs2_used_i = s.u2; in_rd_wr_i = s.wr;
        in_op_a_i = s.a; in_op_b_i = s.b; in_pc_i = s.pc; in_cw_i = s.cw;
        in_op_a_is_rs1_i = s.a1; in_op_b_is_rs2_i = s.b2;
        wb_valid_i = s.wbv; wb_rd_addr_i = s.wbrd; wb_data_i = s.wbd;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input stim_t s);
        bit   held, hz, rdy, acc, iss, ill;
        exp_t e, h;
        drive(s);
        #1;
        held = (q.size() != 0);
        if (held) h = q[0];
        hz = s.v && ((s.u1 && m_pending(s.rs1) && !m_resolved(s.rs1, s))
                  || (s.u2 && m_pending(s.rs2) && !m_resolved(s.rs2, s))
                  || (s.wr && s.rd != 0 && m_pending(s.rd) && !m_resolved(s.rd, s)));
        rdy = (!held || s.ordy) && !hz && !s.flush;
        acc = s.v && rdy;
        iss = held && s.ordy;
        check("in_ready", in_ready_o, rdy);
        check("stall_cnt", stall_cnt_o, stall_m);
        check("busy", busy_o, held || any_pend());
        if (acc) begin
            ill = (s.u1 && s.rs1 >= NR) || (s.u2 && s.rs2 >= NR) || (s.wr && s.rd >= NR);
            e.a   = (s.a1 && m_resolved(s.rs1, s)) ? s.wbd : s.a;
            e.b   = (s.b2 && m_resolved(s.rs2, s)) ? s.wbd : s.b;
            e.pc  = s.pc;
            e.cw  = s.cw;
            e.rd  = s.rd;
            e.ill = ill;
            e.wr  = s.wr && !ill;
        end
        @(posedge clk_i);
        if (s.wbv) pend[s.wbrd] = 1'b0;
        if (iss && h.wr && h.rd != 0) pend[h.rd] = 1'b1;
        if (held && s.flush && !s.ordy) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (hz && !s.flush && stall_m != 32'hFFFF) stall_m++;
        #1;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        rst_i = 1'b1;
        drive(idle());
        repeat (2) @(posedge clk_i);
        q.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        stall_m = 0;
        #1;
        rst_i = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        check("rst_op_a", out_op_a_o, 0);
        check("rst_op_b", out_op_b_o, 0);
        check("rst_pc", out_pc_o, 0);
        check("rst_cw", out_cw_o, 0);
        check("rst_rd", out_rd_addr_o, 0);
        check("rst_rd_wr", out_rd_wr_o, 0);
        check("rst_illegal", out_illegal_o, 0);
    endtask

    // Monitor: whenever the output is valid it must equal the model's head entry.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!in_reset) begin
                check("out_valid", out_valid_o, q.size() != 0);
                if (out_valid_o && q.size() != 0) begin
                    check("op_a", out_op_a_o, q[0].a);
                    check("op_b", out_op_b_o, q[0].b);
                    check("pc", out_pc_o, q[0].pc);
                    check("cw", out_cw_o, q[0].cw);
                    check("rd_addr", out_rd_addr_o, q[0].rd);
                    check("rd_wr", out_rd_wr_o, q[0].wr);
                    check("illegal", out_illegal_o, q[0].ill);
                    if (out_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        stim_t s;
        do_reset();
        check_reset_state();

        // Basic accept and issue; rd=3 becomes outstanding.
        s = idle(); s.v = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.wr = 1;
        s.a = 32'h10; s.b = 32'h20; s.pc = 32'h100; s.cw = 32'hC0DE;
        step(s);
        step(idle());
        step(idle());
        check("t1_busy", busy_o, 1);
        s = idle(); s.wbv = 1; s.wbrd = 3; step(s);

        // RAW stall on x5, then resolved by same-cycle writeback with bypass.
        s = idle(); s.v = 1; s.rd = 5; s.wr = 1; step(s);
        s = idle(); s.v = 1; s.rs1 = 5; s.u1 = 1; s.a1 = 1; s.a = 32'h1111; s.b = 32'h2222;
        repeat (3) step(s);
        s.wbv = 1; s.wbrd = 5; s.wbd = 32'hABCD;
        step(s);
        check("t2_bypass", out_op_a_o, 32'hABCD);
        step(idle());

        // Backpressure for 3 cycles, then back-to-back issue.
        s = idle(); s.v = 1; s.a = 32'hA0; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.v = 1; s.ordy = 0; s.a = 32'hB0 + i; step(s);
        end
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.v = 1; s.a = 32'hC0 + i; s.pc = i; step(s);
        end
        step(idle());

        // Flush while holding an rd=7 writer.
        s = idle(); s.v = 1; s.rd = 7; s.wr = 1; s.ordy = 0; step(s);
        s = idle(); s.v = 1; s.flush = 1; s.ordy = 0; s.a = 32'hDEAD; step(s);
        check("t4_flushed", out_valid_o, 0);
        step(idle());
        check("t4_no_sb7", busy_o, 0);

        // Illegal source address and rd=x0 writer.
        s = idle(); s.v = 1; s.rs1 = 20; s.u1 = 1; s.rd = 4; s.wr = 1; step(s);
        s = idle(); s.v = 1; s.rd = 0; s.wr = 1; step(s);
        step(idle());
        step(idle());

        // Issue of rd=9 coincides with a writeback to 9: the set wins.
        s = idle(); s.v = 1; s.rd = 9; s.wr = 1; step(s);
        s = idle(); s.wbv = 1; s.wbrd = 9; step(s);
        check("t6_sb9_set", busy_o, 1);
        s = idle(); s.wbv = 1; s.wbrd = 9; step(s);

        // Stall counter saturation.
        s = idle(); s.v = 1; s.rd = 5; s.wr = 1; step(s);
        step(idle());
        s = idle(); s.v = 1; s.rs1 = 5; s.u1 = 1;
        repeat (65541) step(s);
        check("t7_saturated", stall_cnt_o, 16'hFFFF);
        s = idle(); s.wbv = 1; s.wbrd = 5; step(s);
        step(idle());

        // Randomised traffic.
        repeat (3000) step(rnd());

        // Reset in the middle of traffic.
        do_reset();
        check_reset_state();
        repeat (500) step(rnd());

        drive(idle());
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
